// File: rtl/ahb_defines_pkg.sv
// Shared AHB-Lite encodings, arbiter state type and request legality check.
package ahb_defines_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic H_OKAY  = 1'b0;
  localparam logic H_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA,
    ARB_LERR
  } ahb_arb_state_e;

  // A request is legal when its size fits the data bus and its address is
  // naturally aligned to that size.
  function automatic logic req_is_legal(input logic [2:0] size,
                                        input logic [2:0] addr_lo,
                                        input int unsigned max_size);
    logic [2:0] mask;
    if (32'(size) > max_size) return 1'b0;
    mask = 3'((4'd1 << size) - 4'd1);
    return (addr_lo & mask) == 3'b000;
  endfunction

endpackage

// File: rtl/ahb_lite_req_arb_rr_arb.sv
// Combinational round-robin picker; search starts one past the pointer.
module rr_arb
  #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = 1
  )
  (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
  );

  // First requester found walking ptr+1, ptr+2, ... modulo NUM_REQ wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_lite_req_arb.sv
// Round-robin sharing of one AHB-Lite master port among NUM_REQ clients,
// one single-beat transfer outstanding at a time.
module ahb_lite_req_arb
  import ahb_defines_pkg::*;
  #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64
  )
  (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]  req_size,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic [AW-1:0]         haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic                  hmastlock,
    output logic [DW-1:0]         hwdata,
    input  logic [DW-1:0]         hrdata,
    input  logic                  hready,
    input  logic                  hresp
  );

  localparam int unsigned IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_SIZE = $clog2(DW / 8);

  ahb_arb_state_e    state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic              write_q, write_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic [2:0]         win_size;
  logic [AW-1:0]      win_addr;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (hreset_n && (state_q == ARB_IDLE)),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign win_size = req_size[arb_idx*3 +: 3];
  assign win_addr = req_addr[arb_idx*AW +: AW];

  // Next-state, grant/response pulses and transfer latch updates.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    write_d   = write_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    htrans    = HTRANS_IDLE;
    // Pulses are suppressed while reset is held so an abandoned transfer
    // never completes, even if hready happens to be high.
    if (hreset_n) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (|arb_gnt) begin
            req_ready = arb_gnt;
            ptr_d     = arb_idx;
            gidx_d    = arb_idx;
            write_d   = req_write[arb_idx];
            addr_d    = win_addr;
            size_d    = win_size;
            wdata_d   = req_wdata[arb_idx*DW +: DW];
            state_d   = req_is_legal(win_size, win_addr[2:0], MAX_SIZE)
                        ? ARB_ADDR : ARB_LERR;
          end
        end
        ARB_ADDR: begin
          htrans = HTRANS_NONSEQ;
          if (hready) state_d = ARB_DATA;
        end
        ARB_DATA: begin
          if (hready) begin
            rsp_valid[gidx_q] = 1'b1;
            rdata_d = write_q ? '0 : hrdata;
            err_d   = (hresp == H_ERROR);
            state_d = ARB_IDLE;
          end
        end
        ARB_LERR: begin
          rsp_valid[gidx_q] = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // State, pointer and latch registers with synchronous active-low reset.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Response data shows the completing value in the pulse cycle and then
  // holds it from the register until the next completion.
  assign rsp_rdata = rdata_d;
  assign rsp_err   = err_d;

  assign haddr     = addr_q;
  assign hwrite    = write_q;
  assign hsize     = size_q;
  assign hwdata    = wdata_q;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DEFAULT;
  assign hmastlock = 1'b0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_hold
    a_req_hold: assert property (@(posedge hclk) disable iff (!hreset_n)
      (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
  end

endmodule

// File: tb/tb_ahb_lite_req_arb.sv
// Directed bench for ahb_lite_req_arb with hand-computed expectations.
module tb_ahb_lite_req_arb;
  import ahb_defines_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*3-1:0]  req_size;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, hwdata, hrdata;
  logic             rsp_err, hwrite, hmastlock, hready, hresp;
  logic [AW-1:0]    haddr;
  logic [1:0]       htrans;
  logic [2:0]       hsize, hburst;
  logic [3:0]       hprot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  ahb_lite_req_arb #(
    .NUM_REQ (NR),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .hmastlock (hmastlock),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [2:0] s, input logic [DW-1:0] d);
    req_valid[i]           = 1'b1;
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_size[i*3 +: 3]     = s;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    hreset_n  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;
    repeat (3) tick();
    hreset_n = 1'b1;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_htrans", htrans, HTRANS_IDLE);
    check("rst_haddr", haddr, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("tie_hburst", hburst, 0);
    check("tie_hprot", hprot, 4'b0011);
    check("tie_hmastlock", hmastlock, 0);

    // Single zero-wait read from requester 0.
    set_req(0, 1'b0, 32'h1000, 3'd3, 64'h0);
    #2;
    check("rd_grant", req_ready, 2'b01);
    check("rd_htrans_T", htrans, HTRANS_IDLE);
    tick(); clr_req(0); #2;
    check("rd_nonseq", htrans, HTRANS_NONSEQ);
    check("rd_haddr", haddr, 32'h1000);
    check("rd_hsize", hsize, 3);
    check("rd_hwrite", hwrite, 0);
    check("rd_no_rsp_T1", rsp_valid, 0);
    tick(); hrdata = 64'hDEADBEEF_CAFEF00D; #2;
    check("rd_rsp_valid", rsp_valid, 2'b01);
    check("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_htrans_T2", htrans, HTRANS_IDLE);
    tick(); hrdata = 64'h0123_4567_89AB_CDEF; #2;
    check("rd_rsp_done", rsp_valid, 0);
    check("rd_rdata_hold", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

    // Write from requester 1 with two data-phase wait states.
    set_req(1, 1'b1, 32'h3000, 3'd3, 64'h11223344_55667788);
    #2;
    check("wr_grant", req_ready, 2'b10);
    tick(); clr_req(1); #2;
    check("wr_nonseq", htrans, HTRANS_NONSEQ);
    check("wr_hwrite", hwrite, 1);
    check("wr_haddr", haddr, 32'h3000);
    tick(); hready = 1'b0; #2;
    check("wr_wait1_hwdata", hwdata, 64'h11223344_55667788);
    check("wr_wait1_rsp", rsp_valid, 0);
    tick(); #2;
    check("wr_wait2_hwdata", hwdata, 64'h11223344_55667788);
    check("wr_wait2_rsp", rsp_valid, 0);
    tick(); hready = 1'b1; hrdata = 64'hFFFF_0000_FFFF_0000; #2;
    check("wr_hwdata_last", hwdata, 64'h11223344_55667788);
    check("wr_rsp_valid", rsp_valid, 2'b10);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_err", rsp_err, 0);
    tick(); #2;
    check("wr_rsp_done", rsp_valid, 0);

    // Both requesters held valid: grants alternate, three cycles apart.
    set_req(0, 1'b0, 32'h100, 3'd3, 64'h0);
    set_req(1, 1'b0, 32'h200, 3'd3, 64'h0);
    for (int k = 0; k < 4; k++) begin
      hrdata = 64'hA0 + 64'(k);
      #2;
      check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (k >= 2) clr_req(k % 2);
      #2;
      check("rr_gap1", req_ready, 0);
      check("rr_nonseq", htrans, HTRANS_NONSEQ);
      check("rr_haddr", haddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick(); #2;
      check("rr_gap2", req_ready, 0);
      check("rr_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rsp_rdata", rsp_rdata, 64'hA0 + 64'(k));
      tick();
    end

    // Two-cycle error response on a read from 0x2000.
    set_req(0, 1'b0, 32'h2000, 3'd2, 64'h0);
    #2;
    check("err_grant", req_ready, 2'b01);
    tick(); clr_req(0); #2;
    check("err_haddr", haddr, 32'h2000);
    check("err_hsize", hsize, 2);
    tick(); hready = 1'b0; hresp = 1'b1; hrdata = 64'hBAD; #2;
    check("err_first_no_rsp", rsp_valid, 0);
    tick(); hready = 1'b1; #2;
    check("err_rsp_valid", rsp_valid, 2'b01);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 64'hBAD);
    tick(); hresp = 1'b0; #2;
    check("err_rsp_done", rsp_valid, 0);
    check("err_hold", rsp_err, 1);

    // Misaligned word access from requester 1: local error, no bus cycle.
    set_req(1, 1'b0, 32'h1002, 3'd2, 64'h0);
    #2;
    check("mis_grant", req_ready, 2'b10);
    tick(); clr_req(1); #2;
    check("mis_htrans", htrans, HTRANS_IDLE);
    check("mis_rsp_valid", rsp_valid, 2'b10);
    check("mis_rsp_err", rsp_err, 1);
    check("mis_rsp_rdata", rsp_rdata, 0);
    tick(); #2;
    check("mis_htrans_after", htrans, HTRANS_IDLE);
    check("mis_rsp_done", rsp_valid, 0);

    // Oversize (16-byte) request on a 64-bit bus.
    set_req(0, 1'b0, 32'h1000, 3'd4, 64'h0);
    #2;
    check("ovs_grant", req_ready, 2'b01);
    tick(); clr_req(0); #2;
    check("ovs_htrans", htrans, HTRANS_IDLE);
    check("ovs_rsp_valid", rsp_valid, 2'b01);
    check("ovs_rsp_err", rsp_err, 1);
    tick(); #2;
    check("ovs_htrans_after", htrans, HTRANS_IDLE);

    // Reset during a waited data phase abandons the transfer.
    set_req(0, 1'b0, 32'h4000, 3'd3, 64'h55);
    #2;
    check("rs_grant", req_ready, 2'b01);
    tick(); clr_req(0); #2;
    check("rs_nonseq", htrans, HTRANS_NONSEQ);
    tick(); hready = 1'b0; #2;
    check("rs_data_no_rsp", rsp_valid, 0);
    hreset_n = 1'b0; #1;
    check("rs_in_reset_rsp", rsp_valid, 0);
    tick(); hreset_n = 1'b1; hready = 1'b1; #2;
    check("rs_htrans", htrans, HTRANS_IDLE);
    check("rs_haddr", haddr, 0);
    check("rs_hwdata", hwdata, 0);
    check("rs_hsize", hsize, 0);
    check("rs_hwrite", hwrite, 0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_rsp_err", rsp_err, 0);
    check("rs_rsp_rdata", rsp_rdata, 0);
    check("rs_req_ready", req_ready, 0);
    set_req(0, 1'b0, 32'h5000, 3'd3, 64'h0);
    set_req(1, 1'b0, 32'h6000, 3'd3, 64'h0);
    #2;
    check("rs_first_grant", req_ready, 2'b01);
    tick(); clr_req(0); #2;
    check("rs_haddr0", haddr, 32'h5000);
    tick(); hrdata = 64'h77; #2;
    check("rs_rsp0", rsp_valid, 2'b01);
    tick(); #2;
    check("rs_second_grant", req_ready, 2'b10);
    tick(); clr_req(1); #2;
    check("rs_haddr1", haddr, 32'h6000);
    tick(); #2;
    check("rs_rsp1", rsp_valid, 2'b10);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
